// File: rtl/mult_issue_arbiter_if.sv
// Signal bundle for mult_issue_arbiter: issue requests, the multiplier port,
// per-requester responses and the sticky protocol-error flag.
interface mult_issue_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 4,
  parameter int OP_BITS       = 8
);
  logic                             flush;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*OP_BITS-1:0]       req_op;
  logic [NUM_REQ*XLEN-1:0]          req_a;
  logic [NUM_REQ*XLEN-1:0]          req_b;
  logic [NUM_REQ*TRANS_ID_BITS-1:0] req_trans_id;
  logic                             mul_valid;
  logic                             mul_ready;
  logic [OP_BITS-1:0]               mul_op;
  logic [XLEN-1:0]                  mul_a;
  logic [XLEN-1:0]                  mul_b;
  logic [TRANS_ID_BITS-1:0]         mul_trans_id;
  logic                             mul_res_valid;
  logic [XLEN-1:0]                  mul_res;
  logic [TRANS_ID_BITS-1:0]         mul_res_trans_id;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [XLEN-1:0]                  rsp_result;
  logic [TRANS_ID_BITS-1:0]         rsp_trans_id;
  logic                             order_err;

  // Environment side: requesters plus the multiplier unit
  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_trans_id,
    output mul_ready, mul_res_valid, mul_res, mul_res_trans_id,
    input  req_ready, mul_valid, mul_op, mul_a, mul_b, mul_trans_id,
    input  rsp_valid, rsp_result, rsp_trans_id, order_err
  );

  // Arbiter side
  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_trans_id,
    input  mul_ready, mul_res_valid, mul_res, mul_res_trans_id,
    output req_ready, mul_valid, mul_op, mul_a, mul_b, mul_trans_id,
    output rsp_valid, rsp_result, rsp_trans_id, order_err
  );
endinterface

// File: rtl/mult_issue_arbiter.sv
// Round-robin sharing of one multiplier among NUM_REQ requesters, with an
// in-order tag FIFO routing results back and flush killing in-flight ops.
module mult_issue_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 4,
  parameter int OP_BITS       = 8,
  parameter int DEPTH         = 4
) (
  input  logic                clk,
  input  logic                rst,
  mult_issue_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0]         idx;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  entry_t                   fifo_r [DEPTH];
  logic [DEPTH-1:0]         killed_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic [IDX_W-1:0]         rr_r;
  logic                     order_err_r;

  logic [IDX_W-1:0]         grant_s;
  logic                     full_s;
  logic                     empty_s;
  logic                     mul_valid_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     err_s;
  entry_t                   head_s;
  logic                     head_killed_s;
  logic [OP_BITS-1:0]       mul_op_s;
  logic [XLEN-1:0]          mul_a_s;
  logic [XLEN-1:0]          mul_b_s;
  logic [TRANS_ID_BITS-1:0] mul_trans_id_s;
  logic [NUM_REQ-1:0]       req_ready_s;
  logic [NUM_REQ-1:0]       rsp_valid_s;

  // full uses the registered count only, so a same-cycle pop never frees a slot
  assign full_s        = (count_r == CNT_W'(DEPTH));
  assign empty_s       = (count_r == {CNT_W{1'b0}});
  assign mul_valid_s   = (|bus.req_valid) & ~full_s & ~bus.flush;
  assign push_s        = mul_valid_s & bus.mul_ready;
  assign pop_s         = bus.mul_res_valid & ~empty_s;
  assign head_s        = fifo_r[rd_ptr_r];
  assign head_killed_s = killed_r[rd_ptr_r];
  assign err_s         = bus.mul_res_valid & (empty_s | (bus.mul_res_trans_id != head_s.trans_id));

  // Round-robin search from rr_r; walking offsets downward leaves the nearest valid requester
  always_comb begin
    grant_s = rr_r;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      grant_s = bus.req_valid[(int'(rr_r) + i) % NUM_REQ] ? IDX_W'((int'(rr_r) + i) % NUM_REQ) : grant_s;
    end
  end

  // Operand/operator mux and one-hot ready for the granted requester
  always_comb begin
    mul_op_s       = {OP_BITS{1'b0}};
    mul_a_s        = {XLEN{1'b0}};
    mul_b_s        = {XLEN{1'b0}};
    mul_trans_id_s = {TRANS_ID_BITS{1'b0}};
    req_ready_s    = {NUM_REQ{1'b0}};
    for (int g = 0; g < NUM_REQ; g++) begin
      mul_op_s       = (grant_s == IDX_W'(g)) ? bus.req_op[g*OP_BITS +: OP_BITS] : mul_op_s;
      mul_a_s        = (grant_s == IDX_W'(g)) ? bus.req_a[g*XLEN +: XLEN] : mul_a_s;
      mul_b_s        = (grant_s == IDX_W'(g)) ? bus.req_b[g*XLEN +: XLEN] : mul_b_s;
      mul_trans_id_s = (grant_s == IDX_W'(g)) ? bus.req_trans_id[g*TRANS_ID_BITS +: TRANS_ID_BITS]
                                              : mul_trans_id_s;
      req_ready_s[g] = (grant_s == IDX_W'(g)) & bus.mul_ready & ~full_s & ~bus.flush;
    end
  end

  // Result routing to the requester recorded at the FIFO head
  always_comb begin
    rsp_valid_s = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid_s[k] = pop_s & (head_s.idx == IDX_W'(k)) & ~head_killed_s & ~bus.flush;
    end
  end

  assign bus.mul_valid    = mul_valid_s;
  assign bus.mul_op       = mul_op_s;
  assign bus.mul_a        = mul_a_s;
  assign bus.mul_b        = mul_b_s;
  assign bus.mul_trans_id = mul_trans_id_s;
  assign bus.req_ready    = req_ready_s;
  assign bus.rsp_valid    = rsp_valid_s;
  assign bus.rsp_result   = bus.mul_res;
  assign bus.rsp_trans_id = bus.mul_res_trans_id;
  assign bus.order_err    = order_err_r;

  // Tag FIFO storage and kill bits; flush marks every entry, push never coincides with flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      killed_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '{idx: {IDX_W{1'b0}}, trans_id: {TRANS_ID_BITS{1'b0}}};
      end
    end else if (bus.flush) begin
      killed_r <= {DEPTH{1'b1}};
    end else if (push_s) begin
      fifo_r[wr_ptr_r]   <= '{idx: grant_s, trans_id: mul_trans_id_s};
      killed_r[wr_ptr_r] <= 1'b0;
    end
  end

  // Pointers, occupancy, round-robin pointer and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      rr_r        <= {IDX_W{1'b0}};
      order_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        rr_r     <= (grant_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : grant_s + IDX_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      if (err_s) begin
        order_err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_issue_arbiter.sv
// Directed scenarios for mult_issue_arbiter; a scoreboard queue holds each
// issued op in order and supplies both the multiplier result and the expected response.
module tb_mult_issue_arbiter;
  localparam int NUM_REQ = 2;
  localparam int XLEN    = 64;
  localparam int TID     = 4;
  localparam int OPB     = 8;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .TRANS_ID_BITS(TID), .OP_BITS(OPB)) bus ();

  mult_issue_arbiter #(
    .NUM_REQ(NUM_REQ), .XLEN(XLEN), .TRANS_ID_BITS(TID), .OP_BITS(OPB), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int             idx;
    logic [XLEN-1:0] res;
    logic [TID-1:0]  id;
    bit             killed;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush            = 1'b0;
    bus.req_valid        = '0;
    bus.req_op           = '0;
    bus.req_a            = '0;
    bus.req_b            = '0;
    bus.req_trans_id     = '0;
    bus.mul_ready        = 1'b0;
    bus.mul_res_valid    = 1'b0;
    bus.mul_res          = '0;
    bus.mul_res_trans_id = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    sb_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TID-1:0] id);
    bus.req_valid[k]                = 1'b1;
    bus.req_op[k*OPB +: OPB]        = 8'(16 + k);
    bus.req_a[k*XLEN +: XLEN]       = a;
    bus.req_b[k*XLEN +: XLEN]       = b;
    bus.req_trans_id[k*TID +: TID]  = id;
  endtask

  task automatic push_exp(input int k, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TID-1:0] id);
    exp_t e;
    e.idx = k; e.res = a * b; e.id = id; e.killed = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic kill_all();
    foreach (sb_q[i]) sb_q[i].killed = 1'b1;
  endtask

  // The bench plays the multiplier: results come back in issue order.
  task automatic drive_res(output exp_t e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin e.idx = 0; e.res = '0; e.id = '0; e.killed = 1'b1; end
    bus.mul_res_valid    = 1'b1;
    bus.mul_res          = e.res;
    bus.mul_res_trans_id = e.id;
  endtask

  function automatic logic [NUM_REQ-1:0] exp_rsp(input exp_t e);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (!e.killed) v[e.idx] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid got %b exp 0", bus.mul_valid); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
    n_checks++; if (bus.order_err !== 1'b0) begin n_fail++; $display("FAIL reset_order_err got %b exp 0", bus.order_err); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    bus.mul_ready = 1'b1;
    set_req(0, 64'd10, 64'd10, 4'd3);
    #2;
    n_checks++; if (bus.mul_valid !== 1'b1) begin n_fail++; $display("FAIL t1_mul_valid got %b exp 1", bus.mul_valid); end
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t1_req_ready got %b exp 01", bus.req_ready); end
    n_checks++; if (bus.mul_a !== 64'd10) begin n_fail++; $display("FAIL t1_mul_a got %0d exp 10", bus.mul_a); end
    n_checks++; if (bus.mul_op !== 8'h10) begin n_fail++; $display("FAIL t1_mul_op got %h exp 10", bus.mul_op); end
    n_checks++; if (bus.mul_trans_id !== 4'd3) begin n_fail++; $display("FAIL t1_mul_id got %0d exp 3", bus.mul_trans_id); end
    push_exp(0, 64'd10, 64'd10, 4'd3);
    step();
    idle();
    drive_res(e);
    #2;
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL t1_rsp_valid got %b exp 01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_result !== 64'd100) begin n_fail++; $display("FAIL t1_rsp_result got %0d exp 100", bus.rsp_result); end
    n_checks++; if (bus.rsp_trans_id !== 4'd3) begin n_fail++; $display("FAIL t1_rsp_id got %0d exp 3", bus.rsp_trans_id); end
    step();
    idle();
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   g;
    logic [TID-1:0] id_g;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      bus.mul_ready = 1'b1;
      if (c < 4) begin
        set_req(0, 64'(c + 2), 64'd3, 4'(c));
        set_req(1, 64'(c + 5), 64'd7, 4'(8 + c));
      end
      if (c >= 2) drive_res(e);
      #2;
      if (c < 4) begin
        g    = c % 2;
        id_g = (g == 0) ? 4'(c) : 4'(8 + c);
        n_checks++; if (bus.req_ready !== 2'(1 << g)) begin n_fail++; $display("FAIL t2_grant c=%0d got %b exp %b", c, bus.req_ready, 2'(1 << g)); end
        n_checks++; if (bus.mul_trans_id !== id_g) begin n_fail++; $display("FAIL t2_mul_id c=%0d got %0d exp %0d", c, bus.mul_trans_id, id_g); end
        if (g == 0) push_exp(0, 64'(c + 2), 64'd3, 4'(c));
        else        push_exp(1, 64'(c + 5), 64'd7, 4'(8 + c));
      end
      if (c >= 2) begin
        n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t2_rsp_valid c=%0d got %b exp %b", c, bus.rsp_valid, exp_rsp(e)); end
        n_checks++; if (bus.rsp_result !== e.res) begin n_fail++; $display("FAIL t2_rsp_result c=%0d got %0d exp %0d", c, bus.rsp_result, e.res); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_full();
    exp_t e;
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      idle();
      bus.mul_ready = 1'b1;
      set_req(0, 64'(c + 1), 64'(c + 1), 4'(c));
      #2;
      n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t3_fill c=%0d got %b exp 01", c, bus.req_ready); end
      push_exp(0, 64'(c + 1), 64'(c + 1), 4'(c));
      step();
    end
    idle();
    bus.mul_ready = 1'b1;
    set_req(0, 64'd9, 64'd9, 4'd4);
    drive_res(e);
    #2;
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL t3_full_mul_valid got %b exp 0", bus.mul_valid); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL t3_full_req_ready got %b exp 00", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t3_full_rsp got %b exp %b", bus.rsp_valid, exp_rsp(e)); end
    step();
    idle();
    bus.mul_ready = 1'b1;
    set_req(0, 64'd9, 64'd9, 4'd4);
    #2;
    n_checks++; if (bus.mul_valid !== 1'b1) begin n_fail++; $display("FAIL t3_after_pop_mul_valid got %b exp 1", bus.mul_valid); end
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t3_after_pop_ready got %b exp 01", bus.req_ready); end
    push_exp(0, 64'd9, 64'd9, 4'd4);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      drive_res(e);
      #2;
      n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t3_drain_rsp i=%0d got %b exp %b", i, bus.rsp_valid, exp_rsp(e)); end
      n_checks++; if (bus.rsp_trans_id !== e.id) begin n_fail++; $display("FAIL t3_drain_id i=%0d got %0d exp %0d", i, bus.rsp_trans_id, e.id); end
      step();
    end
    idle();
    #2;
    n_checks++; if (bus.order_err !== 1'b0) begin n_fail++; $display("FAIL t3_order_err got %b exp 0", bus.order_err); end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      bus.mul_ready = 1'b1;
      set_req(1, 64'(c + 3), 64'd4, 4'(4 + c));
      #2;
      n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL t4_issue c=%0d got %b exp 10", c, bus.req_ready); end
      push_exp(1, 64'(c + 3), 64'd4, 4'(4 + c));
      step();
    end
    idle();
    bus.mul_ready = 1'b1;
    set_req(1, 64'd7, 64'd7, 4'd9);
    bus.flush = 1'b1;
    kill_all();
    drive_res(e);
    #2;
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL t4_flush_mul_valid got %b exp 0", bus.mul_valid); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL t4_flush_ready got %b exp 00", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t4_flush_rsp got %b exp %b", bus.rsp_valid, exp_rsp(e)); end
    step();
    for (int i = 0; i < 2; i++) begin
      idle();
      drive_res(e);
      #2;
      n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t4_killed_rsp i=%0d got %b exp %b", i, bus.rsp_valid, exp_rsp(e)); end
      step();
    end
    idle();
    bus.mul_ready = 1'b1;
    set_req(0, 64'd6, 64'd7, 4'd1);
    #2;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t4_new_issue got %b exp 01", bus.req_ready); end
    push_exp(0, 64'd6, 64'd7, 4'd1);
    step();
    idle();
    drive_res(e);
    #2;
    n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t4_new_rsp got %b exp %b", bus.rsp_valid, exp_rsp(e)); end
    n_checks++; if (bus.rsp_result !== 64'd42) begin n_fail++; $display("FAIL t4_new_result got %0d exp 42", bus.rsp_result); end
    step();
    idle();
    #2;
    n_checks++; if (bus.order_err !== 1'b0) begin n_fail++; $display("FAIL t4_order_err got %b exp 0", bus.order_err); end
  endtask

  task automatic test_errors();
    exp_t e;
    do_reset();
    bus.mul_res_valid    = 1'b1;
    bus.mul_res_trans_id = 4'd7;
    #2;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t5_empty_rsp got %b exp 00", bus.rsp_valid); end
    step();
    for (int i = 0; i < 4; i++) begin
      idle();
      #2;
      n_checks++; if (bus.order_err !== 1'b1) begin n_fail++; $display("FAIL t5_empty_sticky i=%0d got %b exp 1", i, bus.order_err); end
      step();
    end
    do_reset();
    #2;
    n_checks++; if (bus.order_err !== 1'b0) begin n_fail++; $display("FAIL t5_cleared got %b exp 0", bus.order_err); end
    bus.mul_ready = 1'b1;
    set_req(0, 64'd4, 64'd5, 4'd2);
    push_exp(0, 64'd4, 64'd5, 4'd2);
    step();
    idle();
    drive_res(e);
    bus.mul_res_trans_id = 4'd5;
    #2;
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL t5_mismatch_rsp got %b exp 01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_trans_id !== 4'd5) begin n_fail++; $display("FAIL t5_mismatch_id got %0d exp 5", bus.rsp_trans_id); end
    step();
    idle();
    bus.mul_ready = 1'b1;
    set_req(1, 64'd2, 64'd8, 4'd6);
    #2;
    n_checks++; if (bus.order_err !== 1'b1) begin n_fail++; $display("FAIL t5_mismatch_err got %b exp 1", bus.order_err); end
    push_exp(1, 64'd2, 64'd8, 4'd6);
    step();
    idle();
    drive_res(e);
    #2;
    n_checks++; if (bus.rsp_valid !== exp_rsp(e)) begin n_fail++; $display("FAIL t5_next_rsp got %b exp %b", bus.rsp_valid, exp_rsp(e)); end
    step();
    idle();
    #2;
    n_checks++; if (bus.order_err !== 1'b1) begin n_fail++; $display("FAIL t5_err_held got %b exp 1", bus.order_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.mul_res_valid = 1'b1;
    step();
    idle();
    #2;
    n_checks++; if (bus.order_err !== 1'b1) begin n_fail++; $display("FAIL t6_err_setup got %b exp 1", bus.order_err); end
    for (int c = 0; c < 2; c++) begin
      idle();
      bus.mul_ready = 1'b1;
      set_req(0, 64'(c + 1), 64'd2, 4'(c));
      #2;
      n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t6_issue c=%0d got %b exp 01", c, bus.req_ready); end
      step();
    end
    idle();
    rst = 1'b1;
    sb_q.delete();
    #1;
    n_checks++; if (bus.order_err !== 1'b0) begin n_fail++; $display("FAIL t6_async_err got %b exp 0", bus.order_err); end
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async_mul_valid got %b exp 0", bus.mul_valid); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t6_async_rsp got %b exp 00", bus.rsp_valid); end
    step();
    rst = 1'b0;
    bus.mul_res_valid = 1'b1;
    #2;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t6_count_cleared_rsp got %b exp 00", bus.rsp_valid); end
    step();
    idle();
    bus.mul_ready = 1'b1;
    set_req(0, 64'd1, 64'd1, 4'd0);
    set_req(1, 64'd1, 64'd1, 4'd1);
    #2;
    n_checks++; if (bus.order_err !== 1'b1) begin n_fail++; $display("FAIL t6_empty_err got %b exp 1", bus.order_err); end
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL t6_rr_reset got %b exp 01", bus.req_ready); end
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_flush();
    test_errors();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
